// File: rtl/obi_to_apb_bridge.sv
// Bridges the core request/grant/rvalid data bus onto single APB3 transfers,
// one outstanding at a time, with a pready timeout to survive hung slaves.
module obi_to_apb_bridge #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0]     pwdata_o,
    output logic                      pwrite_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [DATA_WIDTH-1:0]     prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                    state_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0]     pwdata_q;
    logic                      pwrite_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      err_q;
    logic                      timeout_hit;

    // A zero TIMEOUT_CYCLES disables the abort path entirely.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    // Grant depends only on state and req_i, never on the APB side.
    assign gnt_o = HRESETn & req_i & (state_q == IDLE);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (we_i && (be_i != '1)) begin
                            // Sub-word writes are rejected without touching the bus.
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            err_q    <= 1'b1;
                            rdata_q  <= '0;
                        end else begin
                            state_q  <= SETUP;
                            psel_q   <= 1'b1;
                            paddr_q  <= addr_i;
                            pwrite_q <= we_i;
                            pwdata_q <= wdata_i;
                        end
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ACCESS: begin
                    if (pready_i) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        err_q     <= pslverr_i;
                        rdata_q   <= pwrite_q ? '0 : prdata_i;
                    end else if (timeout_hit) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    assign paddr_o   = paddr_q;
    assign pwdata_o  = pwdata_q;
    assign pwrite_o  = pwrite_q;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;

endmodule

// File: tb/tb_obi_to_apb_bridge.sv
// Directed table-driven bench for obi_to_apb_bridge with a small APB slave model
// and hand-written sequences for reset behaviour.
module tb_obi_to_apb_bridge;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;
    localparam int STUCK   = 255;
    localparam int NVEC    = 9;

    logic          HCLK;
    logic          HRESETn;
    logic          req_i;
    logic [AW-1:0] addr_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [DW-1:0] wdata_i;
    logic          gnt_o;
    logic          rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          err_o;
    logic [AW-1:0] paddr_o;
    logic [DW-1:0] pwdata_o;
    logic          pwrite_o;
    logic          psel_o;
    logic          penable_o;
    logic [DW-1:0] prdata_i;
    logic          pready_i;
    logic          pslverr_i;

    int totalChecks = 0;
    int badChecks   = 0;
    logic [AW-1:0] lastPaddr;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] prdata;
        logic        pslverr;
        int          waitStates;
        int          expLatency;
        int          expAccess;
        logic        expApb;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs [NVEC];

    obi_to_apb_bridge #(
        .APB_ADDR_WIDTH(AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .req_i    (req_i),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o),
        .paddr_o  (paddr_o),
        .pwdata_o (pwdata_o),
        .pwrite_o (pwrite_o),
        .psel_o   (psel_o),
        .penable_o(penable_o),
        .prdata_i (prdata_i),
        .pready_i (pready_i),
        .pslverr_i(pslverr_i)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mkVec(
        input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [3:0] be, input logic [31:0] prdata, input logic pslverr,
        input int waitStates, input int expLatency, input int expAccess,
        input logic expApb, input logic [31:0] expRdata, input logic expErr);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.prdata = prdata; v.pslverr = pslverr; v.waitStates = waitStates;
        v.expLatency = expLatency; v.expAccess = expAccess; v.expApb = expApb;
        v.expRdata = expRdata; v.expErr = expErr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
        totalChecks++;
        if (act !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // One full transaction: grant, APB phases with slave model, response and idle follow-up.
    task automatic applyStimulus(input int idx, input vec_t v);
        int   c;
        int   accessCycles;
        int   selCycles;
        logic gotRvalid;
        logic seenPsel;
        c = 0; accessCycles = 0; selCycles = 0; gotRvalid = 1'b0; seenPsel = 1'b0;

        @(posedge HCLK); #1;
        req_i     = 1'b1;
        addr_i    = v.addr;
        we_i      = v.we;
        be_i      = v.be;
        wdata_i   = v.wdata;
        prdata_i  = v.prdata;
        pslverr_i = v.pslverr;
        pready_i  = 1'b0;
        @(negedge HCLK);
        checkOutput("gnt_idle", idx, 32'(gnt_o), 32'(1'b1));

        while (!gotRvalid && c < 20) begin
            @(posedge HCLK); #1;
            c++;
            addr_i  = ~v.addr;
            wdata_i = ~v.wdata;
            we_i    = ~v.we;
            be_i    = ~v.be;
            if (penable_o) begin
                pready_i = (v.waitStates != STUCK) && (accessCycles >= v.waitStates);
                accessCycles++;
            end else begin
                pready_i = 1'b0;
            end
            @(negedge HCLK);
            checkOutput("gnt_busy", idx, 32'(gnt_o), 32'(1'b0));
            if (psel_o) begin
                seenPsel = 1'b1;
                checkOutput("penable_phase", idx, 32'(penable_o), 32'(selCycles != 0));
                checkOutput("paddr", idx, paddr_o, v.addr);
                checkOutput("pwrite", idx, 32'(pwrite_o), 32'(v.we));
                if (v.we) checkOutput("pwdata", idx, pwdata_o, v.wdata);
                selCycles++;
            end
            if (rvalid_o) begin
                gotRvalid = 1'b1;
                checkOutput("latency", idx, 32'(c), 32'(v.expLatency));
                checkOutput("rdata", idx, rdata_o, v.expRdata);
                checkOutput("err", idx, 32'(err_o), 32'(v.expErr));
                checkOutput("psel_resp", idx, 32'(psel_o), 32'(1'b0));
                checkOutput("penable_resp", idx, 32'(penable_o), 32'(1'b0));
            end
        end
        if (!gotRvalid) checkOutput("rvalid_seen", idx, 32'(1'b0), 32'(1'b1));
        checkOutput("apb_used", idx, 32'(seenPsel), 32'(v.expApb));
        checkOutput("access_cycles", idx, 32'(accessCycles), 32'(v.expAccess));
        req_i    = 1'b0;
        pready_i = 1'b0;
        if (v.expApb) lastPaddr = v.addr;

        @(posedge HCLK); #1;
        @(negedge HCLK);
        checkOutput("rvalid_pulse", idx, 32'(rvalid_o), 32'(1'b0));
        checkOutput("psel_idle", idx, 32'(psel_o), 32'(1'b0));
        if (v.expApb) checkOutput("paddr_hold", idx, paddr_o, lastPaddr);
    endtask

    task automatic checkResetOutputs(input int idx);
        checkOutput("rst_gnt", idx, 32'(gnt_o), 32'(1'b0));
        checkOutput("rst_rvalid", idx, 32'(rvalid_o), 32'(1'b0));
        checkOutput("rst_rdata", idx, rdata_o, 32'h0);
        checkOutput("rst_err", idx, 32'(err_o), 32'(1'b0));
        checkOutput("rst_paddr", idx, paddr_o, 32'h0);
        checkOutput("rst_pwdata", idx, pwdata_o, 32'h0);
        checkOutput("rst_pwrite", idx, 32'(pwrite_o), 32'(1'b0));
        checkOutput("rst_psel", idx, 32'(psel_o), 32'(1'b0));
        checkOutput("rst_penable", idx, 32'(penable_o), 32'(1'b0));
    endtask

    initial begin
        //                 we    addr          wdata         be     prdata        slverr ws     lat acc apb   rdata         err
        vecs[0] = mkVec(1'b0, 32'h1A10_0004, 32'h0,        4'h0,  32'hDEAD_BEEF, 1'b0, 0,     3,  1,  1'b1, 32'hDEAD_BEEF, 1'b0);
        vecs[1] = mkVec(1'b1, 32'h1A10_0008, 32'h1234_5678, 4'hF, 32'hFFFF_FFFF, 1'b0, 3,     6,  4,  1'b1, 32'h0,         1'b0);
        vecs[2] = mkVec(1'b1, 32'h1A10_000C, 32'hAAAA_5555, 4'h3, 32'h0,         1'b0, 0,     1,  0,  1'b0, 32'h0,         1'b1);
        vecs[3] = mkVec(1'b0, 32'h1A10_0010, 32'h0,        4'hF,  32'hCAFE_F00D, 1'b1, 0,     3,  1,  1'b1, 32'hCAFE_F00D, 1'b1);
        vecs[4] = mkVec(1'b0, 32'h1A10_0014, 32'h0,        4'hF,  32'h55AA_55AA, 1'b0, STUCK, 6,  4,  1'b1, 32'h0,         1'b1);
        vecs[5] = mkVec(1'b0, 32'h1A10_0018, 32'h0,        4'hF,  32'h0000_0042, 1'b0, 1,     4,  2,  1'b1, 32'h0000_0042, 1'b0);
        vecs[6] = mkVec(1'b1, 32'h1A10_001C, 32'h0BAD_F00D, 4'hF, 32'h1111_2222, 1'b1, 0,     3,  1,  1'b1, 32'h0,         1'b1);
        vecs[7] = mkVec(1'b0, 32'h1A10_0020, 32'h0,        4'h5,  32'h8765_4321, 1'b0, 2,     5,  3,  1'b1, 32'h8765_4321, 1'b0);
        vecs[8] = mkVec(1'b0, 32'h1A10_0024, 32'h0,        4'hF,  32'h600D_CAFE, 1'b0, 0,     3,  1,  1'b1, 32'h600D_CAFE, 1'b0);

        HRESETn   = 1'b0;
        req_i     = 1'b1;
        addr_i    = 32'h0;
        we_i      = 1'b0;
        be_i      = 4'h0;
        wdata_i   = 32'h0;
        prdata_i  = 32'h0;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        lastPaddr = '0;

        repeat (2) @(negedge HCLK);
        checkResetOutputs(-1);
        req_i = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        $display("[TB] reset released, running vector table");

        for (int i = 0; i < NVEC - 1; i++) begin
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] reset during ACCESS sequence");
        @(posedge HCLK); #1;
        req_i    = 1'b1;
        addr_i   = 32'h1A10_0100;
        we_i     = 1'b0;
        be_i     = 4'hF;
        prdata_i = 32'h1357_9BDF;
        pready_i = 1'b0;
        @(negedge HCLK);
        checkOutput("rst_seq_gnt", 100, 32'(gnt_o), 32'(1'b1));
        for (int k = 0; k < 10; k++) begin
            @(posedge HCLK); #1;
            req_i = 1'b0;
            if (penable_o) break;
        end
        checkOutput("rst_seq_in_access", 100, 32'(penable_o), 32'(1'b1));
        req_i = 1'b1;
        #2;
        HRESETn = 1'b0;
        #1;
        checkResetOutputs(100);
        for (int k = 0; k < 2; k++) begin
            @(negedge HCLK);
            checkOutput("rst_hold_rvalid", 100 + k, 32'(rvalid_o), 32'(1'b0));
            checkOutput("rst_hold_psel", 100 + k, 32'(psel_o), 32'(1'b0));
        end
        req_i = 1'b0;
        HRESETn = 1'b1;
        lastPaddr = '0;

        applyStimulus(NVEC - 1, vecs[NVEC - 1]);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
